alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Initiator/driver for the ArithmeticLogicUnit operand interface (i_op, i_arg_A, i_arg_B -> o_result, o_status).
//  Accepts ALU commands over a valid/ready stream and buffers them in a small FIFO.
//  Issues one command at a time to the ALU, waits the ALU's fixed latency, then captures result+status.
//  Returns result+status, echoing the command, over a valid/ready response stream. Sits between any command source and the ALU.
// PARAMETERS
//  N            8   operand/result width; must match the ALU's N
//  M            4   status width; must match the ALU's M (status bits are opaque here)
//  ALU_LATENCY  1   clocks from ALU inputs stable to o_result/o_status valid (0 = combinational ALU)
//  DEPTH        4   command FIFO entries; power of two, >=2
// PORTS
//  i_clk         in   1            clock; all logic on rising edge
//  i_reset       in   1            synchronous, active-high reset
//  i_cmd_valid   in   1            command present
//  o_cmd_ready   out  1            FIFO can accept (= !full)
//  i_cmd_op      in   2            ALU opcode
//  i_cmd_a       in   N            operand A
//  i_cmd_b       in   N            operand B
//  o_alu_op      out  2            to ALU i_op
//  o_alu_a       out  N            to ALU i_arg_A
//  o_alu_b       out  N            to ALU i_arg_B
//  i_alu_result  in   N            from ALU o_result
//  i_alu_status  in   M            from ALU o_status
//  o_rsp_valid   out  1            response held
//  i_rsp_ready   in   1            consumer accepts response
//  o_rsp_op      out  2            echo of issued opcode
//  o_rsp_a/_b    out  N each       echo of issued operands
//  o_rsp_result  out  N            captured ALU result
//  o_rsp_status  out  M            captured ALU status
//  o_busy        out  1            FSM not IDLE or FIFO non-empty
//  o_done_cnt    out  16           completed responses, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset (i_reset=1 at edge) clears FIFO pointers and count; FSM->IDLE; o_alu_* = 0; o_rsp_* = 0; o_rsp_valid = 0; o_done_cnt = 0.
//    o_cmd_ready = 1 in the cycle after reset.
//  Reset mid-operation discards queued, in-flight and held commands; no response is emitted for them.
//  Push: i_cmd_valid & o_cmd_ready at an edge writes the FIFO.
//    Full: o_cmd_ready=0 and the push is ignored, even if a pop happens in the same cycle (no pass-through).
//    Simultaneous push and pop when not full: both happen; count unchanged.
//  FSM:
//    IDLE: if FIFO non-empty -> pop head into the ALU drive registers -> WAIT, wcnt=0.
//          If empty, stay in IDLE; o_alu_* hold their last value.
//    WAIT: o_alu_* stable for the whole state; wcnt++ each cycle.
//          When wcnt==ALU_LATENCY, sample i_alu_result/i_alu_status plus the command echo into the rsp registers.
//          Then set o_rsp_valid=1 -> RESP.
//    RESP: hold all o_rsp_* stable while o_rsp_valid & !i_rsp_ready (backpressure unbounded).
//          On i_rsp_ready: o_rsp_valid=0, o_done_cnt++ -> IDLE.
//  Timing: command pushed at edge t; o_alu_* valid from t+1 (if the FSM was IDLE with an empty FIFO).
//    Result sampled at edge t+2+ALU_LATENCY, so o_rsp_valid=1 in the cycle after that edge.
//    Throughput: one command per ALU_LATENCY+3 cycles with i_rsp_ready tied high.
//  Commands complete strictly in FIFO order; only one outstanding ALU operation at a time.
//  Opcode values are passed through unchanged; the sequencer never interprets op or status.
//  FIFO pointers are log2(DEPTH)+1 bits; the extra MSB is the wrap bit. full = MSBs differ and lower bits equal.
// STRUCTURE
//  Package alu_seq_pkg:
//    typedef enum {IDLE, WAIT, RESP} seq_state_e;
//    typedef struct packed alu_cmd_t {op, a, b}.
//  Sub-module alu_cmd_fifo: parameterised on DEPTH and the alu_cmd_t width; exposes push/pop/full/empty.
//  FSM, wait counter, drive/response registers and done counter live in the top module.
// TESTING (bench instantiates ArithmeticLogicUnit #(.N(8),.M(4)) driven by this block)
//  Reset: hold i_reset 2 cycles -> o_rsp_valid=0, o_alu_*=0, o_done_cnt=0, o_cmd_ready=1, o_busy=0.
//  Single op: push op=2'b00,A=8'h05,B=8'h03 at edge t, i_rsp_ready=1.
//    -> o_alu_* = {00,05,03} from t+1; o_rsp_valid high exactly one cycle after edge t+2+ALU_LATENCY.
//    -> o_rsp_result/o_rsp_status equal the ALU outputs at that edge; o_done_cnt=1.
//  Fill/full: i_rsp_ready=0, push 6 cmds (A=1..6).
//    -> cmd 1 is held in RESP; cmds 2-5 fill the FIFO; o_cmd_ready=0, so cmd 6 is not accepted.
//    -> release ready: responses arrive in order A=1..5; o_done_cnt=5.
//  Backpressure: hold i_rsp_ready=0 for 10 cycles during RESP -> all o_rsp_* constant, o_alu_* constant, no new pop.
//  Reset mid-op: assert i_reset during WAIT with 3 queued commands.
//    -> no response appears afterwards; FIFO empty; o_done_cnt=0.
//  All opcodes: push ops 00,01,10,11 with A=8'hF0,B=8'h0F back-to-back.
//    -> four responses echo op in order; each result/status equals the ALU output at its sample edge.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: FSM states and the command record.
package alu_seq_pkg;

  localparam int unsigned OpW      = 2;
  localparam int unsigned DefaultN = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } seq_state_e;

  // Command record at the default operand width; the top builds the same
  // layout at its own N so the FIFO stays width-agnostic.
  typedef struct packed {
    logic [OpW-1:0]      op;
    logic [DefaultN-1:0] a;
    logic [DefaultN-1:0] b;
  } alu_cmd_t;

  // Bits needed to store one command {op, a, b} for operand width n.
  function automatic int unsigned cmd_width(input int unsigned n);
    return OpW + 2 * n;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries of WIDTH bits, wrap-bit pointers, no pass-through.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Drives an ALU one command at a time from a buffered command stream and
// returns result, status and the echoed command over a response stream.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned M           = 4,
  parameter int unsigned ALU_LATENCY = 1,
  parameter int unsigned DEPTH       = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [1:0]    i_cmd_op,
  input  logic [N-1:0]  i_cmd_a,
  input  logic [N-1:0]  i_cmd_b,
  output logic [1:0]    o_alu_op,
  output logic [N-1:0]  o_alu_a,
  output logic [N-1:0]  o_alu_b,
  input  logic [N-1:0]  i_alu_result,
  input  logic [M-1:0]  i_alu_status,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [1:0]    o_rsp_op,
  output logic [N-1:0]  o_rsp_a,
  output logic [N-1:0]  o_rsp_b,
  output logic [N-1:0]  o_rsp_result,
  output logic [M-1:0]  o_rsp_status,
  output logic          o_busy,
  output logic [15:0]   o_done_cnt
);

  localparam int unsigned CmdW   = cmd_width(N);
  localparam int unsigned WcntW  = $clog2(ALU_LATENCY + 2);
  localparam logic [WcntW-1:0] WcntLast = WcntW'(ALU_LATENCY);

  // Same layout as alu_cmd_t, sized to this instance's N.
  typedef struct packed {
    logic [OpW-1:0] op;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
  } cmd_t;

  seq_state_e       state;
  seq_state_e       state_next;
  cmd_t             in_cmd;
  cmd_t             head_cmd;
  cmd_t             drive_cmd;
  cmd_t             rsp_cmd;
  logic [CmdW-1:0]  head_bits;
  logic [WcntW-1:0] wcnt;
  logic [N-1:0]     rsp_result;
  logic [M-1:0]     rsp_status;
  logic             rsp_valid;
  logic [15:0]      done_cnt;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             load_drive;
  logic             capture;
  logic             rsp_done;

  assign in_cmd    = '{op: i_cmd_op, a: i_cmd_a, b: i_cmd_b};
  assign head_cmd  = cmd_t'(head_bits);
  assign fifo_push = i_cmd_valid && !fifo_full;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CmdW)
  ) u_fifo (
    .clk   (i_clk),
    .reset (i_reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_cmd),
    .rdata (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    load_drive = 1'b0;
    capture    = 1'b0;
    rsp_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          load_drive = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (wcnt == WcntLast) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          rsp_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ALU drive registers; they keep their last value while idle.
  always_ff @(posedge i_clk) begin
    if (i_reset)         drive_cmd <= '0;
    else if (load_drive) drive_cmd <= head_cmd;
  end

  // Wait counter: cleared on issue, counts up until the result is sampled.
  always_ff @(posedge i_clk) begin
    if (i_reset)                         wcnt <= '0;
    else if (load_drive)                 wcnt <= '0;
    else if (state == WAIT && !capture)  wcnt <= wcnt + 1'b1;
  end

  // Response registers: loaded once per command, held under backpressure.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rsp_cmd    <= '0;
      rsp_result <= '0;
      rsp_status <= '0;
      rsp_valid  <= 1'b0;
    end else if (capture) begin
      rsp_cmd    <= drive_cmd;
      rsp_result <= i_alu_result;
      rsp_status <= i_alu_status;
      rsp_valid  <= 1'b1;
    end else if (rsp_done) begin
      rsp_valid  <= 1'b0;
    end
  end

  // Completed-response counter, free-running wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset)       done_cnt <= '0;
    else if (rsp_done) done_cnt <= done_cnt + 16'd1;
  end

  assign o_cmd_ready  = !fifo_full;
  assign o_alu_op     = drive_cmd.op;
  assign o_alu_a      = drive_cmd.a;
  assign o_alu_b      = drive_cmd.b;
  assign o_rsp_valid  = rsp_valid;
  assign o_rsp_op     = rsp_cmd.op;
  assign o_rsp_a      = rsp_cmd.a;
  assign o_rsp_b      = rsp_cmd.b;
  assign o_rsp_result = rsp_result;
  assign o_rsp_status = rsp_status;
  assign o_busy       = (state != IDLE) || !fifo_empty;
  assign o_done_cnt   = done_cnt;

  // A stalled response must not change underneath the consumer.
  rsp_stable_a: assert property (@(posedge i_clk) disable iff (i_reset)
      (o_rsp_valid && !i_rsp_ready) |=>
      (o_rsp_valid && $stable(o_rsp_result) && $stable(o_rsp_status) && $stable(o_rsp_a)));

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a one-cycle registered ALU model.
module tb_alu_cmd_sequencer;

  localparam int unsigned N     = 8;
  localparam int unsigned M     = 4;
  localparam int unsigned LAT   = 1;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_cmd_valid = 1'b0;
  logic         o_cmd_ready;
  logic [1:0]   i_cmd_op = '0;
  logic [N-1:0] i_cmd_a = '0;
  logic [N-1:0] i_cmd_b = '0;
  logic [1:0]   o_alu_op;
  logic [N-1:0] o_alu_a;
  logic [N-1:0] o_alu_b;
  logic [N-1:0] alu_result;
  logic [M-1:0] alu_status;
  logic         o_rsp_valid;
  logic         i_rsp_ready = 1'b0;
  logic [1:0]   o_rsp_op;
  logic [N-1:0] o_rsp_a;
  logic [N-1:0] o_rsp_b;
  logic [N-1:0] o_rsp_result;
  logic [M-1:0] o_rsp_status;
  logic         o_busy;
  logic [15:0]  o_done_cnt;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .N           (N),
    .M           (M),
    .ALU_LATENCY (LAT),
    .DEPTH       (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_op     (i_cmd_op),
    .i_cmd_a      (i_cmd_a),
    .i_cmd_b      (i_cmd_b),
    .o_alu_op     (o_alu_op),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .i_alu_result (alu_result),
    .i_alu_status (alu_status),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_op     (o_rsp_op),
    .o_rsp_a      (o_rsp_a),
    .o_rsp_b      (o_rsp_b),
    .o_rsp_result (o_rsp_result),
    .o_rsp_status (o_rsp_status),
    .o_busy       (o_busy),
    .o_done_cnt   (o_done_cnt)
  );

  // ALU stand-in: 00 add, 01 sub, 10 and, 11 xor; status {carry, zero, neg, ovf}.
  function automatic logic [11:0] alu_f(input logic [1:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [8:0] s;
    logic       c;
    logic       v;
    s = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        c = s[8];
        v = (a[7] == b[7]) && (s[7] != a[7]);
      end
      2'b01: begin
        s = {1'b0, a} - {1'b0, b};
        c = s[8];
        v = (a[7] != b[7]) && (s[7] != a[7]);
      end
      2'b10:   s = {1'b0, a & b};
      default: s = {1'b0, a ^ b};
    endcase
    return {c, (s[7:0] == 8'h00), s[7], v, s[7:0]};
  endfunction

  always @(posedge clk) {alu_status, alu_result} <= alu_f(o_alu_op, o_alu_a, o_alu_b);

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] st;
  } vec_t;

  vec_t vecs [12];
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;
  endtask

  task automatic push(input vec_t v, output logic acc);
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_op    = v.op;
    i_cmd_a     = v.a;
    i_cmd_b     = v.b;
    acc         = o_cmd_ready;
    @(posedge clk);
    #1 i_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output logic found);
    found = 1'b0;
    for (int k = 0; k < max && !found; k++) begin
      @(negedge clk);
      if (o_rsp_valid) found = 1'b1;
    end
  endtask

  task automatic check_rsp(input int idx);
    check($sformatf("rsp%0d_op", idx), 32'(o_rsp_op), 32'(vecs[idx].op));
    check($sformatf("rsp%0d_a", idx), 32'(o_rsp_a), 32'(vecs[idx].a));
    check($sformatf("rsp%0d_b", idx), 32'(o_rsp_b), 32'(vecs[idx].b));
    check($sformatf("rsp%0d_result", idx), 32'(o_rsp_result), 32'(vecs[idx].res));
    check($sformatf("rsp%0d_status", idx), 32'(o_rsp_status), 32'(vecs[idx].st));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic found;
    logic seen;
    vec_t single;

    // Opcode sweep, A=F0 B=0F
    vecs[0]  = '{2'b00, 8'hF0, 8'h0F, 8'hFF, 4'b0010};
    vecs[1]  = '{2'b01, 8'hF0, 8'h0F, 8'hE1, 4'b0010};
    vecs[2]  = '{2'b10, 8'hF0, 8'h0F, 8'h00, 4'b0100};
    vecs[3]  = '{2'b11, 8'hF0, 8'h0F, 8'hFF, 4'b0010};
    // Fill set A=1..6, B=10 add; entry 9 must be refused
    vecs[4]  = '{2'b00, 8'h01, 8'h10, 8'h11, 4'b0000};
    vecs[5]  = '{2'b00, 8'h02, 8'h10, 8'h12, 4'b0000};
    vecs[6]  = '{2'b00, 8'h03, 8'h10, 8'h13, 4'b0000};
    vecs[7]  = '{2'b00, 8'h04, 8'h10, 8'h14, 4'b0000};
    vecs[8]  = '{2'b00, 8'h05, 8'h10, 8'h15, 4'b0000};
    vecs[9]  = '{2'b00, 8'h06, 8'h10, 8'h16, 4'b0000};
    // Backpressure pair
    vecs[10] = '{2'b01, 8'h20, 8'h05, 8'h1B, 4'b0000};
    vecs[11] = '{2'b10, 8'h3C, 8'h0F, 8'h0C, 4'b0000};
    single   = '{2'b00, 8'h05, 8'h03, 8'h08, 4'b0000};

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("reset_alu_a", 32'(o_alu_a), 32'd0);
    check("reset_alu_b", 32'(o_alu_b), 32'd0);
    check("reset_alu_op", 32'(o_alu_op), 32'd0);
    check("reset_done_cnt", 32'(o_done_cnt), 32'd0);
    check("reset_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check("reset_busy", 32'(o_busy), 32'd0);

    // Single op, cycle-exact
    i_rsp_ready = 1'b1;
    push(single, acc);
    check("single_accept", 32'(acc), 32'd1);
    @(negedge clk);
    check("single_t0_alu_a", 32'(o_alu_a), 32'd0);
    check("single_t0_busy", 32'(o_busy), 32'd1);
    @(negedge clk);
    check("single_t1_alu", 32'({o_alu_op, o_alu_a, o_alu_b}), 32'({2'b00, 8'h05, 8'h03}));
    @(negedge clk);
    check("single_t2_rsp_valid", 32'(o_rsp_valid), 32'd0);
    @(negedge clk);
    check("single_t3_rsp_valid", 32'(o_rsp_valid), 32'd1);
    check("single_t3_result", 32'(o_rsp_result), 32'h08);
    check("single_t3_status", 32'(o_rsp_status), 32'h0);
    @(negedge clk);
    check("single_t4_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("single_done_cnt", 32'(o_done_cnt), 32'd1);
    check("single_busy", 32'(o_busy), 32'd0);

    // Fill / full with response stalled
    do_reset();
    i_rsp_ready = 1'b0;
    for (int i = 4; i <= 9; i++) begin
      push(vecs[i], acc);
      check($sformatf("fill_accept%0d", i - 3), 32'(acc), (i < 9) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("fill_cmd_ready", 32'(o_cmd_ready), 32'd0);
    check("fill_rsp_valid", 32'(o_rsp_valid), 32'd1);
    check_rsp(4);
    i_rsp_ready = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      wait_rsp(20, found);
      check($sformatf("fill_found%0d", i - 3), 32'(found), 32'd1);
      check_rsp(i);
    end
    wait_rsp(15, found);
    check("fill_no_sixth", 32'(found), 32'd0);
    check("fill_done_cnt", 32'(o_done_cnt), 32'd5);
    check("fill_busy", 32'(o_busy), 32'd0);

    // Backpressure: response held 10 cycles, second command stays queued
    do_reset();
    i_rsp_ready = 1'b0;
    push(vecs[10], acc);
    push(vecs[11], acc);
    wait_rsp(20, found);
    check("bp_found", 32'(found), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(o_rsp_valid), 32'd1);
      check("bp_rsp", 32'({o_rsp_op, o_rsp_a, o_rsp_b, o_rsp_result, o_rsp_status}),
            32'({2'b01, 8'h20, 8'h05, 8'h1B, 4'h0}));
      check("bp_alu", 32'({o_alu_op, o_alu_a, o_alu_b}), 32'({2'b01, 8'h20, 8'h05}));
    end
    i_rsp_ready = 1'b1;
    wait_rsp(20, found);
    check("bp_found2", 32'(found), 32'd1);
    check_rsp(11);
    @(posedge clk);
    @(negedge clk);
    check("bp_done_cnt", 32'(o_done_cnt), 32'd2);

    // Reset during WAIT with three commands queued
    do_reset();
    i_rsp_ready = 1'b1;
    for (int i = 4; i <= 8; i++) push(vecs[i], acc);
    @(posedge clk);
    @(negedge clk);
    check("mid_in_wait_alu_a", 32'(o_alu_a), 32'h02);
    check("mid_in_wait_rsp_valid", 32'(o_rsp_valid), 32'd0);
    i_reset = 1'b1;
    @(posedge clk);
    #1 i_reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_rsp_valid) seen = 1'b1;
    end
    check("mid_no_rsp", 32'(seen), 32'd0);
    check("mid_done_cnt", 32'(o_done_cnt), 32'd0);
    check("mid_busy", 32'(o_busy), 32'd0);
    check("mid_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check("mid_alu_a", 32'(o_alu_a), 32'd0);

    // All opcodes back-to-back
    do_reset();
    i_rsp_ready = 1'b1;
    for (int i = 0; i <= 3; i++) push(vecs[i], acc);
    for (int i = 0; i <= 3; i++) begin
      wait_rsp(20, found);
      check($sformatf("ops_found%0d", i), 32'(found), 32'd1);
      check_rsp(i);
    end
    @(posedge clk);
    @(negedge clk);
    check("ops_done_cnt", 32'(o_done_cnt), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
